// File: rtl/hw_config_pkg.sv
// Shared configuration for the instruction fetch path: widths, memory timing,
// instruction word type and fetch-state encoding.
package hw_config_pkg;

    localparam int INSTR_L              = 32;
    localparam int INSTR_MEM_ADDR_L     = 14;
    localparam int INSTR_MEM_RD_LATENCY = 1;

    typedef logic [INSTR_L-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous show-ahead FIFO holding prefetched instructions; the head word is
// visible on rdata_o whenever empty_o is low. Storage is not reset.
module instr_prefetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (cnt_q != CNT_FULL);
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
        else if (!do_push && do_pop) cnt_d = cnt_q - CNT_ONE;
        // Flush wins over any push/pop in the same cycle.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential instruction-memory reads for a
// start/count program and streams the returned words to decode through a prefetch FIFO.
module instr_fetch_unit #(
    parameter int INSTR_L          = hw_config_pkg::INSTR_L,
    parameter int INSTR_MEM_ADDR_L = hw_config_pkg::INSTR_MEM_ADDR_L,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [INSTR_MEM_ADDR_L-1:0] start_addr,
    input  logic [INSTR_MEM_ADDR_L:0]   n_instr,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_rd_en,
    output logic [INSTR_MEM_ADDR_L-1:0] mem_rd_addr,
    input  logic [INSTR_L-1:0]          mem_rd_data,
    output logic [INSTR_L-1:0]          instr_out,
    output logic                        instr_vld,
    input  logic                        instr_rdy
);

    import hw_config_pkg::*;

    localparam int LAT   = INSTR_MEM_RD_LATENCY;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [INSTR_MEM_ADDR_L-1:0] ADDR_ONE = INSTR_MEM_ADDR_L'(1);
    localparam logic [INSTR_MEM_ADDR_L:0]   NUM_ONE  = (INSTR_MEM_ADDR_L+1)'(1);

    fetch_state_e state_q, state_d;
    logic [INSTR_MEM_ADDR_L-1:0] addr_q, addr_d;
    logic [INSTR_MEM_ADDR_L:0]   rem_q, rem_d;    // reads still to issue
    logic [INSTR_MEM_ADDR_L:0]   left_q, left_d;  // handshakes still to see
    logic                        done_q, done_d;
    logic [LAT-1:0]              pipe_q, pipe_d;  // one bit per outstanding read
    logic [CNT_W-1:0]            fifo_cnt;
    logic                        fifo_empty;
    logic                        rd_en, hs, flush;
    int                          inflight;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < LAT; i++) inflight += int'(pipe_q[i]);
    end

    assign hs = instr_vld && instr_rdy;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        left_d  = left_q;
        done_d  = 1'b0;
        flush   = 1'b0;
        rd_en   = (state_q == FETCH) && ((int'(fifo_cnt) + inflight) < FIFO_DEPTH);

        if (rd_en) begin
            addr_d = addr_q + ADDR_ONE;
            rem_d  = rem_q - NUM_ONE;
        end
        if (hs) left_d = left_q - NUM_ONE;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_instr == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                        addr_d  = start_addr;
                        rem_d   = n_instr;
                        left_d  = n_instr;
                    end
                end
            end
            FETCH: begin
                if (rd_en && rem_q == NUM_ONE) state_d = DRAIN;
            end
            DRAIN: begin
                if (hs && left_q == NUM_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            flush   = 1'b1;
        end
    end

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = rd_en;
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            left_q  <= '0;
            done_q  <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            done_q  <= done_d;
            pipe_q  <= flush ? '0 : pipe_d;
        end
    end

    instr_prefetch_fifo #(
        .WIDTH (INSTR_L),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (pipe_q[LAT-1]),
        .wdata_i (mem_rd_data),
        .pop_i   (hs),
        .rdata_o (instr_out),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign instr_vld   = !fifo_empty;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetch programs plus hand-written
// abort, reset and priority sequences, against a simple addressed memory model.
module tb_instr_fetch_unit;
    import hw_config_pkg::*;

    localparam int AW    = 14;
    localparam int DEPTH = 4;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, instr_rdy = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   n_instr = '0;
    logic          busy, done, mem_rd_en, instr_vld;
    logic [AW-1:0] mem_rd_addr;
    instr_t        mem_rd_data, instr_out;

    always #5 clk = ~clk;

    instr_fetch_unit #(.INSTR_L(32), .INSTR_MEM_ADDR_L(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .n_instr(n_instr),
        .abort(abort), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .instr_out(instr_out),
        .instr_vld(instr_vld), .instr_rdy(instr_rdy)
    );

    function automatic instr_t mem_fn(input logic [AW-1:0] a);
        return {8'hC3, 2'b01, a, 8'h5A};
    endfunction

    // One-cycle-latency memory; stale cycles return a poison word.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_fn(mem_rd_addr) : 32'hDEAD_BEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs reads, handshakes and done pulses of the current test.
    int            test_id = 0, seen_id = 0;
    logic [AW-1:0] rd_q[$];
    instr_t        out_q[$];
    int            hs_q[$];
    int            st, frd, fvld, fbusy, done_cnt, done_cyc, busy_cnt, stab_err, issued, accepted, max_out;
    logic          prev_stall;
    instr_t        prev_out;

    always @(negedge clk) begin
        if (seen_id != test_id) begin
            seen_id = test_id;
            rd_q.delete(); out_q.delete(); hs_q.delete();
            st = -1; frd = -1; fvld = -1; fbusy = -1; done_cnt = 0; done_cyc = -1;
            busy_cnt = 0; stab_err = 0; issued = 0; accepted = 0; max_out = 0;
            prev_stall = 1'b0; prev_out = '0;
        end
        if (!rst) begin
            if (start && st < 0) st = cyc;
            if (mem_rd_en) begin
                rd_q.push_back(mem_rd_addr);
                if (frd < 0) frd = cyc;
                issued++;
            end
            if (instr_vld && fvld < 0) fvld = cyc;
            if (busy) begin
                busy_cnt++;
                if (fbusy < 0) fbusy = cyc;
            end
            if (prev_stall && (instr_vld !== 1'b1 || instr_out !== prev_out)) stab_err++;
            if (instr_vld && instr_rdy) begin
                out_q.push_back(instr_out);
                hs_q.push_back(cyc);
                accepted++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = instr_vld && !instr_rdy;
            prev_out   = instr_out;
            if (issued - accepted > max_out) max_out = issued - accepted;
        end
    end

    int n_checks = 0, n_errs = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic begin_test();
        test_id++;
        @(negedge clk);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW:0]   n;
        int            mode;        // 0: rdy high, 1: rdy low 10 cycles, 2: random rdy
        bit            poke;        // pulse a second start while busy
        int            exp_reads;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        int            stall_reads; // reads expected after the 10-cycle stall, -1 if n/a
    } vec_t;

    vec_t vecs[6];

    task automatic run_prog(input int idx, input vec_t v);
        int            k;
        bit            to;
        logic [AW-1:0] a;
        instr_t        got;
        begin_test();
        @(posedge clk); #1;
        start = 1'b1; start_addr = v.addr; n_instr = v.n; instr_rdy = (v.mode == 0);
        @(posedge clk); #1;
        k = 0; to = 1'b0;
        while (done_cnt == 0) begin
            if (k >= 1500) begin
                to = 1'b1;
                break;
            end
            case (v.mode)
                0:       instr_rdy = 1'b1;
                1:       instr_rdy = (k >= 10);
                default: instr_rdy = 1'($urandom_range(0, 1));
            endcase
            if (v.stall_reads >= 0 && k == 10)
                check($sformatf("v%0d_reads_while_stalled", idx), rd_q.size(), v.stall_reads);
            if (v.poke && k == 3) begin
                start = 1'b1; start_addr = 14'h3000; n_instr = 15'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        instr_rdy = 1'b0;

        check($sformatf("v%0d_timeout", idx), 32'(to), 0);
        check($sformatf("v%0d_read_count", idx), rd_q.size(), v.exp_reads);
        check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
        check($sformatf("v%0d_delivered", idx), out_q.size(), 32'(v.n));
        check($sformatf("v%0d_busy_after", idx), 32'(busy), 0);
        check($sformatf("v%0d_stable_under_stall", idx), stab_err, 0);
        check($sformatf("v%0d_occupancy_le_depth", idx), 32'(max_out <= DEPTH), 1);
        if (rd_q.size() > 0) begin
            check($sformatf("v%0d_first_addr", idx), 32'(rd_q[0]), 32'(v.exp_first));
            check($sformatf("v%0d_last_addr", idx), 32'(rd_q[$]), 32'(v.exp_last));
        end
        for (int i = 0; i < int'(v.n); i++) begin
            a   = v.addr + AW'(i);
            got = (i < out_q.size()) ? out_q[i] : 'x;
            check($sformatf("v%0d_instr%0d", idx, i), got, mem_fn(a));
            if (i < rd_q.size()) check($sformatf("v%0d_addr%0d", idx, i), 32'(rd_q[i]), 32'(a));
        end
        if (v.mode == 0 && v.n != 0 && hs_q.size() > 0) begin
            check($sformatf("v%0d_first_read_lat", idx), frd - st, 1);
            check($sformatf("v%0d_first_vld_lat", idx), fvld - st, 3);
            check($sformatf("v%0d_first_hs_lat", idx), hs_q[0] - st, 3);
            check($sformatf("v%0d_hs_span", idx), hs_q[$] - hs_q[0], int'(v.n) - 1);
            check($sformatf("v%0d_done_after_last_hs", idx), done_cyc - hs_q[$], 1);
            check($sformatf("v%0d_busy_start", idx), fbusy - st, 1);
        end
        if (v.n == 0) begin
            check($sformatf("v%0d_done_lat", idx), done_cyc - st, 1);
            check($sformatf("v%0d_busy_cycles", idx), busy_cnt, 0);
        end
        if (v.stall_reads >= 0)
            check($sformatf("v%0d_max_outstanding", idx), max_out, DEPTH);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_rd_en", 32'(mem_rd_en), 0);
        check("reset_vld", 32'(instr_vld), 0);
        check("reset_addr", 32'(mem_rd_addr), 0);
        rst = 1'b0;

        vecs[0] = '{14'h0010, 15'd8,   0, 1'b0, 8,   14'h0010, 14'h0017, -1};
        vecs[1] = '{14'h0020, 15'd6,   1, 1'b1, 6,   14'h0020, 14'h0025,  4};
        vecs[2] = '{14'h3FFE, 15'd4,   0, 1'b0, 4,   14'h3FFE, 14'h0001, -1};
        vecs[3] = '{14'h0100, 15'd0,   0, 1'b0, 0,   14'h0000, 14'h0000, -1};
        vecs[4] = '{14'h1234, 15'd100, 2, 1'b0, 100, 14'h1234, 14'h1297, -1};
        vecs[5] = '{14'h3FF0, 15'd20,  2, 1'b0, 20,  14'h3FF0, 14'h0003, -1};
        for (int i = 0; i < 6; i++) run_prog(i, vecs[i]);

        // Abort with three words buffered and one read still in flight.
        begin_test();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 14'h0040; n_instr = 15'd10; instr_rdy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_pre_vld", 32'(instr_vld), 1);
        check("abort_pre_reads", rd_q.size(), 4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_vld", 32'(instr_vld), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_rd_en", 32'(mem_rd_en), 0);
        instr_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        instr_rdy = 1'b0;
        check("abort_no_done", done_cnt, 0);
        check("abort_nothing_delivered", out_q.size(), 0);
        check("abort_reads_total", rd_q.size(), 4);
        run_prog(6, '{14'h0080, 15'd3, 0, 1'b0, 3, 14'h0080, 14'h0082, -1});

        // Reset in the middle of a program.
        begin_test();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 14'h0500; n_instr = 15'd8; instr_rdy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; instr_rdy = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_vld", 32'(instr_vld), 0);
        check("midrst_rd_en", 32'(mem_rd_en), 0);
        check("midrst_addr", 32'(mem_rd_addr), 0);
        repeat (5) @(posedge clk);
        #1;
        instr_rdy = 1'b0;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_nothing_delivered", out_q.size(), 0);

        // Abort and start in the same cycle: abort wins.
        begin_test();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; start_addr = 14'h0010; n_instr = 15'd5;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("prio_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("prio_no_reads", rd_q.size(), 0);
        check("prio_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
